mic_spi_sampler: RTL and testbench

MIC_SPI_SAMPLER -- requirements
Module: mic_spi_sampler

---
 rtl/mic_spi_sampler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mic_spi_sampler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_spi_sampler.sv
// mic_spi_sampler: periodically reads one 16-bit sample from an SPI (mode 0)
// microphone ADC and queues it in a first-word fall-through FIFO that has a
// sticky overflow flag and a registered level interrupt.
module mic_spi_sampler #(
   parameter int unsigned CLK_DIV    = 4,      // SCK half-period in clock cycles (1..255)
   parameter logic [7:0]  CMD        = 8'h03,  // read command sent at the start of each transfer
   parameter int unsigned FIFO_DEPTH = 8,      // sample FIFO entries, power of two
   parameter int unsigned IRQ_LEVEL  = 4       // irq asserts at or above this level
) (
   input  logic                        clock,
   input  logic                        resetb,
   input  logic                        enable,
   input  logic [15:0]                 period,
   output logic                        spi_csb,
   output logic                        spi_sck,
   output logic                        spi_sdo,
   input  logic                        spi_sdi,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [15:0]                 rd_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   input  logic                        overflow_clr,
   output logic                        irq
);

   localparam int unsigned      PTR_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned      LVL_W      = PTR_W + 1;
   localparam logic [15:0]      DIV_LOAD   = 16'(CLK_DIV - 1);
   localparam logic [4:0]       LAST_BIT   = 5'd23;
   localparam logic [4:0]       FIRST_DATA = 5'd8;
   localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] IRQ_LVL    = LVL_W'(IRQ_LEVEL);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CS_SETUP,
      ST_SHIFT,
      ST_CS_HOLD
   } state_e;

   // ---------------------------------------------------------------- sequencer
   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;        // WAIT countdown or phase countdown
   logic [4:0]  bit_q, bit_d;        // SCK period index within SHIFT, 0..23
   logic        csb_q, csb_d;
   logic        sck_q, sck_d;
   logic        sdo_q, sdo_d;
   logic [7:0]  cmd_sr_q, cmd_sr_d;  // command bits still to be sent, MSB next
   logic [15:0] rx_sr_q, rx_sr_d;    // sample being assembled, MSB first
   logic        push;
   logic [15:0] wait_load;

   // A period of 0 still leaves one idle cycle between transfers.
   assign wait_load = (period == 16'd0) ? 16'd1 : period;

   // Next-state and next-output logic for the transfer sequencer.
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      csb_d    = csb_q;
      sck_d    = sck_q;
      sdo_d    = sdo_q;
      cmd_sr_d = cmd_sr_q;
      rx_sr_d  = rx_sr_q;
      push     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            csb_d = 1'b1;
            sck_d = 1'b0;
            sdo_d = 1'b0;
            if (enable) begin
               state_d = ST_WAIT;
               cnt_d   = wait_load;
            end
         end

         ST_WAIT: begin
            if (!enable) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
            end else if (cnt_q <= 16'd1) begin
               state_d  = ST_CS_SETUP;
               cnt_d    = DIV_LOAD;
               csb_d    = 1'b0;
               sck_d    = 1'b0;
               sdo_d    = CMD[7];
               cmd_sr_d = CMD;
               rx_sr_d  = 16'd0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         // Chip select settles before the first clock; sdo already holds CMD[7].
         ST_CS_SETUP: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_SHIFT;
               cnt_d   = DIV_LOAD;
               bit_d   = 5'd0;
               sck_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         ST_SHIFT: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!sck_q) begin
               // End of low phase: raise sck and capture sdi on this same edge.
               sck_d = 1'b1;
               cnt_d = DIV_LOAD;
               if (bit_q >= FIRST_DATA) begin
                  rx_sr_d = {rx_sr_q[14:0], spi_sdi};
               end
            end else if (bit_q == LAST_BIT) begin
               state_d = ST_CS_HOLD;
               cnt_d   = DIV_LOAD;
               sck_d   = 1'b0;
               sdo_d   = 1'b0;
            end else begin
               // Start of the next low phase: present the next command bit
               // (zeros once the command has been shifted out).
               bit_d    = bit_q + 5'd1;
               cnt_d    = DIV_LOAD;
               sck_d    = 1'b0;
               cmd_sr_d = {cmd_sr_q[6:0], 1'b0};
               sdo_d    = cmd_sr_q[6];
            end
         end

         ST_CS_HOLD: begin
            if (cnt_q == 16'd0) begin
               push  = 1'b1;
               csb_d = 1'b1;
               if (enable) begin
                  state_d = ST_WAIT;
                  cnt_d   = wait_load;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = 16'd0;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            csb_d   = 1'b1;
            sck_d   = 1'b0;
            sdo_d   = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered SPI outputs; reset aborts any transfer.
   always_ff @(posedge clock) begin
      // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
      if (!resetb) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 16'd0;
         bit_q    <= 5'd0;
         csb_q    <= 1'b1;
         sck_q    <= 1'b0;
         sdo_q    <= 1'b0;
         cmd_sr_q <= 8'd0;
         rx_sr_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         csb_q    <= csb_d;
         sck_q    <= sck_d;
         sdo_q    <= sdo_d;
         cmd_sr_q <= cmd_sr_d;
         rx_sr_q  <= rx_sr_d;
      end
   end

   assign spi_csb = csb_q;
   assign spi_sck = sck_q;
   assign spi_sdo = sdo_q;

   // ---------------------------------------------------------------- sample FIFO
   logic [15:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             overflow_q, overflow_d;
   logic             irq_q, irq_d;
   logic             full;
   logic             pop;
   logic             wr_en;
   logic             drop;

   assign full  = (level_q == FULL_LVL);
   assign pop   = (level_q != '0) && rd_ready;
   // A coincident pop frees the slot, so a push into a full FIFO still lands.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   // Pointer, level, overflow and irq next-state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      // A new drop wins over a clear in the same cycle.
      overflow_d = drop | (overflow_q & ~overflow_clr);
      irq_d      = (level_q >= IRQ_LVL);
   end

   // FIFO control registers.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         irq_q      <= irq_d;
      end
   end

   // Sample storage.
   always_ff @(posedge clock) begin
      // NOTE: storage has no reset; an entry is only visible once the level counts it.
      if (wr_en) begin
         mem_q[wr_ptr_q] <= rx_sr_q;
      end
   end

   assign rd_valid   = (level_q != '0);
   assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 16'd0;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_mic_spi_sampler.sv
// tb_mic_spi_sampler: directed sequence of transfers with random samples,
// random junk in the discarded bits and random idle periods, checked against
// a queue-based model of the FIFO and a cycle-counting SPI slave/monitor.
module tb_mic_spi_sampler;

   localparam int unsigned CLK_DIV = 4;
   localparam logic [7:0]  CMD     = 8'h03;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned IRQ_LVL = 4;
   localparam int unsigned XFER    = 50 * CLK_DIV;

   logic        clock = 1'b0;
   logic        resetb;
   logic        enable;
   logic [15:0] period;
   logic        spi_csb;
   logic        spi_sck;
   logic        spi_sdo;
   logic        spi_sdi = 1'b0;
   logic        rd_valid;
   logic        rd_ready;
   logic [15:0] rd_data;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic        overflow_clr;
   logic        irq;

   mic_spi_sampler #(
      .CLK_DIV(CLK_DIV), .CMD(CMD), .FIFO_DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LVL)
   ) dut (
      .clock(clock), .resetb(resetb), .enable(enable), .period(period),
      .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr),
      .irq(irq)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // ---------------------------------------------------------------- slave + bus monitor
   logic [23:0] next_frame = '0;  // frame the slave returns on the next transfer
   logic [23:0] slave_frame = '0;
   logic [23:0] sdo_bits = '0;    // sdo captured at each sck rise
   int          rise_cnt = 0;
   int          low_cnt = 0;
   int          high_cnt = 0;
   int          last_low = 0;
   int          last_gap = 0;
   int          done_cnt = 0;
   int          fall_cnt = 0;
   logic        prev_csb = 1'b1;
   logic        prev_sck = 1'b0;

   always @(negedge clock) begin
      if (spi_csb === 1'b0) begin
         if (prev_csb) begin
            last_gap    = high_cnt;
            rise_cnt    = 0;
            low_cnt     = 0;
            sdo_bits    = '0;
            slave_frame = next_frame;
            fall_cnt++;
         end
         low_cnt++;
         if (!prev_sck && spi_sck) begin
            sdo_bits = {sdo_bits[22:0], spi_sdo};
            rise_cnt++;
         end
      end else begin
         if (!prev_csb) begin
            last_low = low_cnt;
            high_cnt = 0;
            done_cnt++;
         end
         high_cnt++;
      end
      spi_sdi  = (spi_csb === 1'b0 && rise_cnt < 24) ? slave_frame[5'(23 - rise_cnt)] : 1'b0;
      prev_csb = (spi_csb === 1'b0) ? 1'b0 : 1'b1;
      prev_sck = (spi_sck === 1'b1);
   end

   // ---------------------------------------------------------------- reference model
   logic [15:0] exp_q[$];
   logic        exp_ovf = 1'b0;

   task automatic model_xfer(input logic [15:0] s, input bit do_pop, input bit clr);
      bit drop;
      if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
      drop = (exp_q.size() == DEPTH);
      if (!drop) exp_q.push_back(s);
      exp_ovf = drop ? 1'b1 : (clr ? 1'b0 : exp_ovf);
   endtask

   function automatic logic [15:0] max1(input logic [15:0] p);
      return (p == 16'd0) ? 16'd1 : p;
   endfunction

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_done();
      int base = done_cnt;
      int n = 0;
      while (done_cnt == base && n < 2000) begin tick(); n++; end
      check("done_timeout", 32'(done_cnt != base), 32'd1);
   endtask

   task automatic wait_rise(input int target);
      int n = 0;
      while (!(spi_csb === 1'b0 && rise_cnt == target) && n < 2000) begin tick(); n++; end
      check("rise_timeout", 32'(rise_cnt), 32'(target));
   endtask

   task automatic wait_last_low();
      int n = 0;
      while (!(spi_csb === 1'b0 && low_cnt == XFER) && n < 2000) begin tick(); n++; end
      check("last_low_timeout", 32'(low_cnt), 32'(XFER));
   endtask

   task automatic end_checks(input logic [15:0] gap_exp, input bit use_gap);
      check("csb_low_cycles", 32'(last_low), 32'(XFER));
      if (use_gap) check("csb_high_gap", 32'(last_gap), 32'(gap_exp));
      check("sdo_frame", 32'(sdo_bits), {8'h0, CMD, 16'h0});
      check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      check("rd_data", 32'(rd_data), 32'((exp_q.size() != 0) ? exp_q[0] : 16'h0));
      check("overflow", 32'(overflow), 32'(exp_ovf));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_csb"}, 32'(spi_csb), 32'd1);
      check({tag, "_sck"}, 32'(spi_sck), 32'd0);
      check({tag, "_sdo"}, 32'(spi_sdo), 32'd0);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      check({tag, "_level"}, 32'(fifo_level), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_irq"}, 32'(irq), 32'd0);
   endtask

   // ---------------------------------------------------------------- sequence
   logic [15:0] cur;
   logic [15:0] gap_exp;
   int          lvl_prev;
   int          base_fall;

   initial begin
      resetb       = 1'b0;
      enable       = 1'b0;
      period       = 16'd10;
      rd_ready     = 1'b0;
      overflow_clr = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      resetb = 1'b1;
      tick();

      // First transfer: known sample, period 10.
      cur        = 16'hA5C3;
      next_frame = {8'($urandom), cur};
      enable     = 1'b1;
      wait_done();
      model_xfer(cur, 1'b0, 1'b0);
      end_checks(16'd0, 1'b0);
      check("first_sample", 32'(rd_data), 32'h0000A5C3);

      // Transfers 2..9 with no consumer: fill, then one drop. Periods 0 and 1
      // first, then random ones.
      gap_exp    = max1(period);
      cur        = 16'($urandom);
      next_frame = {8'($urandom), cur};
      period     = 16'd0;
      for (int k = 2; k <= 9; k++) begin
         lvl_prev = exp_q.size();
         wait_done();
         model_xfer(cur, 1'b0, 1'b0);
         end_checks(gap_exp, 1'b1);
         check("irq_before_update", 32'(irq), 32'(lvl_prev >= IRQ_LVL));
         gap_exp    = max1(period);
         cur        = 16'($urandom);
         next_frame = {8'($urandom), cur};
         period     = (k == 2) ? 16'd1 : 16'($urandom_range(2, 12));
         tick();
         check("irq_after_update", 32'(irq), 32'(exp_q.size() >= IRQ_LVL));
      end

      // Clear the sticky flag, then push into a full FIFO with a coincident pop.
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      exp_ovf      = 1'b0;
      check("overflow_cleared", 32'(overflow), 32'(exp_ovf));
      wait_last_low();
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      model_xfer(cur, 1'b1, 1'b0);
      end_checks(gap_exp, 1'b1);

      // Drop coinciding with overflow_clr: the flag must stay set.
      gap_exp    = max1(period);
      cur        = 16'($urandom);
      next_frame = {8'($urandom), cur};
      period     = 16'($urandom_range(2, 12));
      wait_last_low();
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      model_xfer(cur, 1'b0, 1'b1);
      end_checks(gap_exp, 1'b1);

      // Drop enable at SHIFT bit 5, drain the FIFO while the transfer finishes.
      gap_exp    = max1(period);
      cur        = 16'($urandom);
      next_frame = {8'($urandom), cur};
      wait_rise(5);
      enable   = 1'b0;
      rd_ready = 1'b1;
      while (exp_q.size() > 0) begin
         check("drain_valid", 32'(rd_valid), 32'd1);
         check("drain_data", 32'(rd_data), 32'(exp_q[0]));
         tick();
         void'(exp_q.pop_front());
      end
      check("drained_level", 32'(fifo_level), 32'd0);
      tick();
      check("drained_irq", 32'(irq), 32'd0);
      wait_done();
      model_xfer(cur, 1'b1, 1'b0);
      end_checks(gap_exp, 1'b1);
      tick();
      void'(exp_q.pop_front());
      rd_ready = 1'b0;
      check("popped_level", 32'(fifo_level), 32'(exp_q.size()));
      check("popped_valid", 32'(rd_valid), 32'd0);
      base_fall = fall_cnt;
      repeat (300) tick();
      check("idle_no_csb_activity", 32'(fall_cnt), 32'(base_fall));
      check("idle_csb_high", 32'(spi_csb), 32'd1);
      check("sticky_overflow", 32'(overflow), 32'(exp_ovf));

      // Reset during SHIFT bit 12 aborts the transfer without a push.
      enable     = 1'b1;
      next_frame = {8'($urandom), 16'($urandom)};
      wait_rise(12);
      resetb = 1'b0;
      tick();
      enable = 1'b0;
      check_reset_outputs("abort");
      tick();
      resetb = 1'b1;
      repeat (20) tick();
      check("after_abort_level", 32'(fifo_level), 32'd0);
      check("after_abort_valid", 32'(rd_valid), 32'd0);
      check("after_abort_csb", 32'(spi_csb), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
